// File: rtl/alu_exec_ctrl_if.sv
// Request/operand/result bundle between the datapath sequencer and the ALU execution controller.
// The master side is the surrounding datapath (request source and ALU); the slave side is alu_exec_ctrl.
interface alu_exec_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 8
);
   logic             op_valid;
   logic             op_ready;
   logic [2:0]       opcode;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             src_acc;
   logic             use_carry;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic             alu_cin;
   logic [SEL_W-1:0] alu_sel;
   logic [WIDTH-1:0] acc_bus;
   logic             c_in;
   logic             z_in;
   logic             gr_in;
   logic             e_in;
   logic [WIDTH-1:0] acc_q;
   logic [3:0]       flags_q;
   logic             done;
   logic             illegal;

   modport master (
      output op_valid, opcode, a_in, b_in, src_acc, use_carry,
      output acc_bus, c_in, z_in, gr_in, e_in,
      input  op_ready, alu_a, alu_b, alu_cin, alu_sel, acc_q, flags_q, done, illegal
   );

   modport slave (
      input  op_valid, opcode, a_in, b_in, src_acc, use_carry,
      input  acc_bus, c_in, z_in, gr_in, e_in,
      output op_ready, alu_a, alu_b, alu_cin, alu_sel, acc_q, flags_q, done, illegal
   );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Sequences one ALU operation per request: latch operands, pulse a one-hot select for one cycle,
// then capture the ALU result and flags {gr, e, c, z} into the accumulator/flag registers.
module alu_exec_ctrl #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 8
) (
   input logic           clk,
   input logic           rst,
   alu_exec_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             cin_q, cin_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [3:0]       flags_q, flags_d;
   logic             illegal_q, illegal_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         cin_q     <= 1'b0;
         sel_q     <= '0;
         acc_q     <= '0;
         flags_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         cin_q     <= cin_d;
         sel_q     <= sel_d;
         acc_q     <= acc_d;
         flags_q   <= flags_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      cin_d     = cin_q;
      sel_d     = '0;
      acc_d     = acc_q;
      flags_d   = flags_q;
      illegal_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.op_valid) begin
               if (bus.opcode == 3'd7) begin
                  illegal_d = 1'b1;
               end else begin
                  a_d     = bus.src_acc ? acc_q : bus.a_in;
                  b_d     = bus.b_in;
                  cin_d   = bus.use_carry & flags_q[1];
                  op_d    = bus.opcode;
                  // Select is registered so it is glitch-free and zero outside EXEC.
                  sel_d   = SEL_W'(1) << bus.opcode;
                  state_d = EXEC;
               end
            end
         end
         EXEC: begin
            acc_d      = bus.acc_bus;
            flags_d[0] = bus.z_in;
            if (op_q <= 3'd2) flags_d[1] = bus.c_in;
            if (op_q == 3'd6) flags_d[3:2] = {bus.gr_in, bus.e_in};
            state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.op_ready = (state_q == IDLE);
   assign bus.done     = (state_q == DONE);
   assign bus.illegal  = illegal_q;
   assign bus.alu_a    = a_q;
   assign bus.alu_b    = b_q;
   assign bus.alu_cin  = cin_q;
   assign bus.alu_sel  = sel_q;
   assign bus.acc_q    = acc_q;
   assign bus.flags_q  = flags_q;
endmodule
